// File: rtl/mksync_pkg.sv
// rtl/mksync_pkg.sv - shared defaults and packed-vector helper for mksync_multi
package mksync_pkg;

    localparam int CH_DEF      = 2;
    localparam int CW_DEF      = 13;
    localparam bit IN_SYNC_DEF = 1'b1;

    // Widest packed per-channel vector (8 channels x 16 bits).
    localparam int MAXW = 128;

    // Shifts a packed per-channel vector so channel i lands in the low bits;
    // the caller truncates the result to its field width.
    function automatic logic [MAXW-1:0] ch_field(input logic [MAXW-1:0] v, input int i, input int w);
        return v >> (i * w);
    endfunction

endpackage

// File: rtl/mksync_multi_if.sv
// rtl/mksync_multi_if.sv - blank/sync bus between a video source and mksync_multi
interface mksync_multi_if
    import mksync_pkg::*;
#(
    parameter int CH = CH_DEF,
    parameter int CW = CW_DEF
) ();

    logic [CH-1:0]    nBLANK;
    logic [CH*CW-1:0] CON;
    logic [CH*CW-1:0] COFF;
    logic [CH-1:0]    POL;
    logic [CH-1:0]    nSYNC;
    logic             nCSYNC;
    logic [CH*CW-1:0] BLEN;
    logic [CH-1:0]    BLEN_VLD;

    modport master (
        output nBLANK, CON, COFF, POL,
        input  nSYNC, nCSYNC, BLEN, BLEN_VLD
    );

    modport slave (
        input  nBLANK, CON, COFF, POL,
        output nSYNC, nCSYNC, BLEN, BLEN_VLD
    );

endinterface

// File: rtl/mksync_ch.sv
// rtl/mksync_ch.sv - one blank-to-sync channel: sync-in, counter, shadow offsets, compare, length capture
module mksync_ch
    import mksync_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter bit IN_SYNC = IN_SYNC_DEF
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          nblank,
    input  logic [CW-1:0] con,
    input  logic [CW-1:0] coff,
    output logic          s,
    output logic [CW-1:0] blen,
    output logic          blen_vld
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          bl;
    logic          bl_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] con_s;
    logic [CW-1:0] coff_s;

    generate
        if (IN_SYNC) begin : g_sync
            logic [1:0] sync_q;
            // Two-flop synchroniser, reset to idle so release never looks like a blank.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) sync_q <= 2'b11;
                else       sync_q <= {sync_q[0], nblank};
            end
            assign bl = sync_q[1];
        end else begin : g_nosync
            assign bl = nblank;
        end
    endgenerate

    // Idle: clear the counter and track the offsets; blank: count up to saturation and freeze offsets.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt    <= '0;
            con_s  <= '0;
            coff_s <= '0;
        end else if (bl) begin
            cnt    <= '0;
            con_s  <= con;
            coff_s <= coff;
        end else if (cnt != CNT_MAX) begin
            cnt    <= cnt + 1'b1;
        end
    end

    // Sync is active strictly between the two offsets while blanking.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) s <= 1'b0;
        else       s <= !bl && (con_s < cnt) && (cnt < coff_s);
    end

    // On the first idle cycle after a blank, capture its (saturated) length and strobe once.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bl_q     <= 1'b1;
            blen     <= '0;
            blen_vld <= 1'b0;
        end else begin
            bl_q     <= bl;
            blen_vld <= bl & ~bl_q;
            if (bl && !bl_q) blen <= cnt;
        end
    end

endmodule

// File: rtl/mksync_multi.sv
// rtl/mksync_multi.sv - multi-channel blank-to-sync generator with composite sync
module mksync_multi
    import mksync_pkg::*;
#(
    parameter int CH      = CH_DEF,
    parameter int CW      = CW_DEF,
    parameter bit IN_SYNC = IN_SYNC_DEF
) (
    input  logic          CLK,
    input  logic          nRST,
    mksync_multi_if.slave bus
);

    logic [CH-1:0] s;
    logic [CH-1:0] vld;
    logic [CW-1:0] blen [CH];
    logic          ncsync_q;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            logic [CW-1:0] con_i;
            logic [CW-1:0] coff_i;

            assign con_i  = CW'(ch_field(MAXW'(bus.CON), i, CW));
            assign coff_i = CW'(ch_field(MAXW'(bus.COFF), i, CW));

            mksync_ch #(.CW(CW), .IN_SYNC(IN_SYNC)) u_ch (
                .CLK      (CLK),
                .nRST     (nRST),
                .nblank   (bus.nBLANK[i]),
                .con      (con_i),
                .coff     (coff_i),
                .s        (s[i]),
                .blen     (blen[i]),
                .blen_vld (vld[i])
            );
        end
    endgenerate

    // Composite sync follows the channel syncs one cycle later, regardless of polarity.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) ncsync_q <= 1'b1;
        else       ncsync_q <= ~|s;
    end

    // Flatten per-channel lengths onto the packed bus.
    always_comb begin
        bus.BLEN = '0;
        for (int i = 0; i < CH; i++) bus.BLEN[i*CW +: CW] = blen[i];
    end

    // Polarity is applied after the register so a POL change shows immediately.
    assign bus.nSYNC    = ~(s ^ bus.POL);
    assign bus.nCSYNC   = ncsync_q;
    assign bus.BLEN_VLD = vld;

endmodule

// File: tb/tb_mksync_multi.sv
// tb/tb_mksync_multi.sv - directed self-checking bench for mksync_multi
module tb_mksync_multi;

    logic CLK  = 1'b0;
    logic nRST = 1'b1;
    always #5 CLK = ~CLK;

    mksync_multi_if #(.CH(2), .CW(13)) a ();
    mksync_multi_if #(.CH(2), .CW(13)) b ();
    mksync_multi_if #(.CH(1), .CW(4))  c ();

    mksync_multi #(.CH(2), .CW(13), .IN_SYNC(1'b0)) u0 (.CLK(CLK), .nRST(nRST), .bus(a));
    mksync_multi #(.CH(2), .CW(13), .IN_SYNC(1'b1)) u1 (.CLK(CLK), .nRST(nRST), .bus(b));
    mksync_multi #(.CH(1), .CW(4),  .IN_SYNC(1'b0)) u2 (.CLK(CLK), .nRST(nRST), .bus(c));

    int tests = 0;
    int fails = 0;
    int fst [3][2];
    int wid [3][2];
    int nv  [3][2];
    int vst [3][2];
    int bln [3][2];
    int cfst [3];
    int cwid [3];

    task automatic chk(input string tag, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set0(input int con, input int coff);
        a.CON[12:0]  = 13'(con);
        b.CON[12:0]  = 13'(con);
        a.COFF[12:0] = 13'(coff);
        b.COFF[12:0] = 13'(coff);
        idle(1);
    endtask

    task automatic rec(input int d, input int k, input logic [1:0] ns, input logic [1:0] pol,
                       input logic nc, input logic [1:0] v, input int bl0, input int bl1);
        for (int ch = 0; ch < 2; ch++) begin
            if (ns[ch] == pol[ch]) begin
                if (fst[d][ch] < 0) fst[d][ch] = k;
                wid[d][ch]++;
            end
            if (v[ch]) begin
                nv[d][ch]++;
                vst[d][ch] = k;
                bln[d][ch] = (ch == 1) ? bl1 : bl0;
            end
        end
        if (!nc) begin
            if (cfst[d] < 0) cfst[d] = k;
            cwid[d]++;
        end
    endtask

    // ch0 blanks for steps [0, len0), ch1 for [st1, st1+len1); step k samples just after edge k.
    task automatic run(input int len0, input int st1, input int len1, input int total,
                       input int chg_step, input int chg_con);
        for (int d = 0; d < 3; d++) begin
            cfst[d] = -1;
            cwid[d] = 0;
            for (int ch = 0; ch < 2; ch++) begin
                fst[d][ch] = -1; wid[d][ch] = 0; nv[d][ch] = 0; vst[d][ch] = -1; bln[d][ch] = -1;
            end
        end
        for (int k = 0; k < total; k++) begin
            if (k == chg_step) begin
                a.CON[12:0] = 13'(chg_con);
                b.CON[12:0] = 13'(chg_con);
            end
            a.nBLANK = {!(k >= st1 && k < st1 + len1), !(k < len0)};
            b.nBLANK = a.nBLANK;
            c.nBLANK = a.nBLANK[0];
            @(posedge CLK);
            #1;
            rec(0, k, a.nSYNC, a.POL, a.nCSYNC, a.BLEN_VLD, int'(a.BLEN[12:0]), int'(a.BLEN[25:13]));
            rec(1, k, b.nSYNC, b.POL, b.nCSYNC, b.BLEN_VLD, int'(b.BLEN[12:0]), int'(b.BLEN[25:13]));
            rec(2, k, {1'b1, c.nSYNC}, {1'b0, c.POL}, c.nCSYNC, {1'b0, c.BLEN_VLD}, int'(c.BLEN), 0);
        end
    endtask

    initial begin
        #2 nRST = 1'b0;
        a.nBLANK = 2'b11;             b.nBLANK = 2'b11;
        a.CON  = {13'd2, 13'd3};      b.CON  = {13'd2, 13'd3};
        a.COFF = {13'd6, 13'd8};      b.COFF = {13'd6, 13'd8};
        a.POL  = 2'b10;               b.POL  = 2'b10;
        c.nBLANK = 1'b1; c.CON = 4'd2; c.COFF = 4'd15; c.POL = 1'b0;
        #1;
        chk("rst_nsync", a.nSYNC, 2'b01);
        chk("rst_ncsync", a.nCSYNC, 1);
        chk("rst_blen", a.BLEN, 0);
        chk("rst_vld", a.BLEN_VLD, 0);
        a.POL = 2'b00;
        #1;
        chk("rst_pol_comb", a.nSYNC, 2'b11);
        a.POL = 2'b10;
        idle(3);
        nRST = 1'b1;
        idle(3);

        // Basic 20-cycle blank, con=3 coff=8
        run(20, 0, 0, 30, -1, 0);
        chk("t1_start", fst[0][0], 4);
        chk("t1_width", wid[0][0], 4);
        chk("t1_nvld", nv[0][0], 1);
        chk("t1_vld_step", vst[0][0], 20);
        chk("t1_blen", bln[0][0], 20);
        chk("t1_csync_start", cfst[0], 5);
        chk("t1_csync_width", cwid[0], 4);
        chk("t1_ch1_quiet", nv[0][1], 0);
        chk("t1s_start", fst[1][0], 6);
        chk("t1s_width", wid[1][0], 4);
        chk("t1s_nvld", nv[1][0], 1);
        chk("t1s_vld_step", vst[1][0], 22);
        chk("t1s_blen", bln[1][0], 20);
        idle(2);
        chk("t1_blen_hold", a.BLEN[12:0], 20);

        // Empty window and one-cycle window
        set0(8, 8);
        run(10, 0, 0, 20, -1, 0);
        chk("t2_empty", wid[0][0], 0);
        chk("t2s_empty", wid[1][0], 0);
        chk("t2_blen", bln[0][0], 10);
        set0(5, 7);
        run(10, 0, 0, 20, -1, 0);
        chk("t2_one_start", fst[0][0], 6);
        chk("t2_one_width", wid[0][0], 1);
        chk("t2s_one_start", fst[1][0], 8);
        chk("t2s_one_width", wid[1][0], 1);

        // CON changes 3 -> 10 mid-blank; only the next blank sees it
        set0(3, 14);
        run(20, 0, 0, 30, 3, 10);
        chk("t3a_start", fst[0][0], 4);
        chk("t3a_width", wid[0][0], 10);
        chk("t3as_start", fst[1][0], 6);
        chk("t3as_width", wid[1][0], 10);
        idle(1);
        run(20, 0, 0, 30, -1, 0);
        chk("t3b_start", fst[0][0], 11);
        chk("t3b_width", wid[0][0], 3);
        chk("t3bs_start", fst[1][0], 13);

        // Overlapping blanks, ch1 active-high
        set0(3, 8);
        run(20, 3, 10, 30, -1, 0);
        chk("t4_ch0_start", fst[0][0], 4);
        chk("t4_ch0_width", wid[0][0], 4);
        chk("t4_ch1_high_start", fst[0][1], 6);
        chk("t4_ch1_high_width", wid[0][1], 3);
        chk("t4_csync_start", cfst[0], 5);
        chk("t4_csync_width", cwid[0], 5);
        chk("t4_ch1_blen", bln[0][1], 10);
        chk("t4_ch1_vld_step", vst[0][1], 13);
        chk("t4s_csync_start", cfst[1], 7);
        chk("t4s_csync_width", cwid[1], 5);

        // One-cycle blank on ch1
        run(0, 2, 1, 10, -1, 0);
        chk("t5_blen1", bln[0][1], 1);
        chk("t5_nvld1", nv[0][1], 1);
        chk("t5_no_pulse", wid[0][1], 0);
        chk("t5s_blen1", bln[1][1], 1);

        // Reset during a blank with sync active
        a.nBLANK = 2'b00; b.nBLANK = 2'b00; c.nBLANK = 1'b0;
        idle(6);
        chk("t6_pre_nsync0", a.nSYNC[0], 0);
        chk("t6_pre_ncsync", a.nCSYNC, 0);
        nRST = 1'b0;
        #1;
        chk("t6_rst_nsync", a.nSYNC, 2'b01);
        chk("t6_rst_ncsync", a.nCSYNC, 1);
        chk("t6_rst_vld", a.BLEN_VLD, 0);
        chk("t6_rst_blen0", a.BLEN[12:0], 0);
        a.nBLANK = 2'b11; b.nBLANK = 2'b11; c.nBLANK = 1'b1;
        idle(2);
        nRST = 1'b1;
        run(0, 0, 0, 10, -1, 0);
        chk("t6_no_vld0", nv[0][0], 0);
        chk("t6_no_vld1", nv[0][1], 0);
        chk("t6s_no_vld0", nv[1][0], 0);
        chk("t6_no_sync", fst[0][0], -1);

        // CW=4 saturation: 40-cycle blank, con=2 coff=15
        run(40, 0, 0, 50, -1, 0);
        chk("t7_start", fst[2][0], 3);
        chk("t7_width", wid[2][0], 12);
        chk("t7_blen", bln[2][0], 15);
        chk("t7_nvld", nv[2][0], 1);
        chk("t7_vld_step", vst[2][0], 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
